// File: rtl/logic_ex_pkg.sv
// Shared constants for the two-switch logic-gate demonstrator.
// LED bit positions are fixed by the board wiring.
package logic_ex_pkg;

  localparam int SW_W  = 2;
  localparam int LED_W = 4;

  localparam int LED_NOT = 0;
  localparam int LED_AND = 1;
  localparam int LED_OR  = 2;
  localparam int LED_XOR = 3;

endpackage

// File: rtl/logic_ex_gates.sv
// Purely combinational switch-to-LED gate network.
// Each LED bit is a single 1-bit gate of the two switches.
module logic_ex_gates
  import logic_ex_pkg::*;
(
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led
);

  always_comb begin
    led          = '0;
    led[LED_NOT] = ~sw[0];
    led[LED_AND] = sw[1] & sw[0];
    led[LED_OR]  = sw[1] | sw[0];
    led[LED_XOR] = sw[1] ^ sw[0];
  end

endmodule

// File: rtl/logic_ex_core.sv
// Board-level gate demonstrator: combinational LEDs plus a registered
// observation path (LED copy, switch-change pulse, saturating change count).
module logic_ex_core
  import logic_ex_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LED,
  output logic [LED_W-1:0]  led_q,
  output logic              sw_chg,
  output logic [CNT_W-1:0]  chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SW_W-1:0] sw_prev;

  logic_ex_gates u_gates (
    .sw  (SW),
    .led (LED)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      sw_prev <= '0;
      sw_chg  <= 1'b0;
    end else begin
      led_q   <= LED;
      sw_prev <= SW;
      sw_chg  <= (SW != sw_prev);
    end
  end

  // Counts registered change pulses, so it trails the switch change by two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt <= '0;
    end else if (sw_chg && (chg_cnt != CNT_MAX)) begin
      chg_cnt <= chg_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_ex_core.sv
// Scoreboard bench for logic_ex_core: a default-width instance and a
// 2-bit-counter instance share stimulus so saturation is seen alongside counting.
module tb_logic_ex_core;

  typedef struct {
    int step;
    int led;
    int ledQ;
    int chg;
    int cnt8;
    int cnt2;
  } expect_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] SW;
  logic [3:0] led8, ledQ8, led2, ledQ2;
  logic       chg8, chg2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  expect_t expQ[$];
  int compared;
  int mismatched;
  int stepNum;

  logic_ex_core #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW),
    .LED(led8), .led_q(ledQ8), .sw_chg(chg8), .chg_cnt(cnt8)
  );

  logic_ex_core #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .SW(SW),
    .LED(led2), .led_q(ledQ2), .sw_chg(chg2), .chg_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(input int step, input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL step %0d %s: got %0d, expected %0d", step, name, act, req);
    end
  endfunction

  // Monitor: pops each expectation as soon as it is presented and checks both instances.
  initial begin
    expect_t e;
    forever begin
      wait (expQ.size() != 0);
      e = expQ.pop_front();
      cmp(e.step, "LED",       int'(led8),  e.led);
      cmp(e.step, "LED_w2",    int'(led2),  e.led);
      cmp(e.step, "led_q",     int'(ledQ8), e.ledQ);
      cmp(e.step, "led_q_w2",  int'(ledQ2), e.ledQ);
      cmp(e.step, "sw_chg",    int'(chg8),  e.chg);
      cmp(e.step, "sw_chg_w2", int'(chg2),  e.chg);
      cmp(e.step, "chg_cnt",   int'(cnt8),  e.cnt8);
      cmp(e.step, "chg_cnt_w2",int'(cnt2),  e.cnt2);
    end
  end

  task automatic applyStimulus(input logic [1:0] sw);
    SW = sw;
    #1;
  endtask

  task automatic checkOutput(input int led, input int ledQ, input int chg,
                             input int c8, input int c2);
    expect_t e;
    stepNum++;
    e.step = stepNum;
    e.led  = led;
    e.ledQ = ledQ;
    e.chg  = chg;
    e.cnt8 = c8;
    e.cnt2 = c2;
    expQ.push_back(e);
    #0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed LED per switch value: {XOR, OR, AND, NOT}.
  int ledTab[4] = '{4'b0001, 4'b1100, 4'b1101, 4'b0110};

  initial begin
    int waitCnt;
    compared   = 0;
    mismatched = 0;
    stepNum    = 0;
    rst_n      = 1'b0;
    SW         = 2'b00;
    #3;
    checkOutput(4'b0001, 0, 0, 0, 0);

    // Sweep while held in reset: LED follows gates, registers stay cleared.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i));
      checkOutput(ledTab[i], 0, 0, 0, 0);
      #99;
      checkOutput(ledTab[i], 0, 0, 0, 0);
    end

    applyStimulus(2'b00);
    checkOutput(4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput(4'b0001, 4'b0001, 0, 0, 0);

    // Five separated changes; the 2-bit counter saturates at 3.
    applyStimulus(2'b01);
    checkOutput(4'b1100, 4'b0001, 0, 0, 0);
    tick(); checkOutput(4'b1100, 4'b1100, 1, 0, 0);
    tick(); checkOutput(4'b1100, 4'b1100, 0, 1, 1);
    tick(); checkOutput(4'b1100, 4'b1100, 0, 1, 1);

    applyStimulus(2'b11);
    checkOutput(4'b0110, 4'b1100, 0, 1, 1);
    tick(); checkOutput(4'b0110, 4'b0110, 1, 1, 1);
    tick(); checkOutput(4'b0110, 4'b0110, 0, 2, 2);
    tick(); checkOutput(4'b0110, 4'b0110, 0, 2, 2);

    applyStimulus(2'b10);
    checkOutput(4'b1101, 4'b0110, 0, 2, 2);
    tick(); checkOutput(4'b1101, 4'b1101, 1, 2, 2);
    tick(); checkOutput(4'b1101, 4'b1101, 0, 3, 3);
    tick(); checkOutput(4'b1101, 4'b1101, 0, 3, 3);

    applyStimulus(2'b00);
    tick(); checkOutput(4'b0001, 4'b0001, 1, 3, 3);
    tick(); checkOutput(4'b0001, 4'b0001, 0, 4, 3);

    applyStimulus(2'b01);
    tick(); checkOutput(4'b1100, 4'b1100, 1, 4, 3);
    tick(); checkOutput(4'b1100, 4'b1100, 0, 5, 3);
    tick(); checkOutput(4'b1100, 4'b1100, 0, 5, 3);

    // Asynchronous reset between edges clears registers at once.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(4'b1100, 0, 0, 0, 0);
    applyStimulus(2'b00);
    checkOutput(4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); checkOutput(4'b0001, 4'b0001, 0, 0, 0);

    applyStimulus(2'b01);
    tick(); checkOutput(4'b1100, 4'b1100, 1, 0, 0);
    tick(); checkOutput(4'b1100, 4'b1100, 0, 1, 1);
    applyStimulus(2'b00);
    tick(); checkOutput(4'b0001, 4'b0001, 1, 1, 1);
    tick(); checkOutput(4'b0001, 4'b0001, 0, 2, 2);
    #3;
    rst_n = 1'b0;
    #2;
    checkOutput(4'b0001, 0, 0, 0, 0);

    // Toggle every clock for four cycles: sw_chg stays high, count reaches 4.
    @(negedge clk);
    rst_n = 1'b1;
    tick(); checkOutput(4'b0001, 4'b0001, 0, 0, 0);
    applyStimulus(2'b01);
    tick(); checkOutput(4'b1100, 4'b1100, 1, 0, 0);
    applyStimulus(2'b00);
    tick(); checkOutput(4'b0001, 4'b0001, 1, 1, 1);
    applyStimulus(2'b01);
    tick(); checkOutput(4'b1100, 4'b1100, 1, 2, 2);
    applyStimulus(2'b00);
    tick(); checkOutput(4'b0001, 4'b0001, 1, 3, 3);
    tick(); checkOutput(4'b0001, 4'b0001, 0, 4, 3);
    tick(); checkOutput(4'b0001, 4'b0001, 0, 4, 3);

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 100) begin
      #1;
      waitCnt++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
